pp_loop_tracker: RTL and testbench
==================================

# pp_loop_tracker

Synthesizable monitor that sits directly downstream of the pipelined-loop observation interface in the Dilithium HLS simulation harness. It samples the loop FSM state and the per-iteration start/end qualifiers every cycle. It tracks loop entry, iterations in flight, drain and exit, and produces registered iteration counts, a loop-finish pulse and sticky error/stall flags for the scoreboard.

## Interface
- FSM_WIDTH, 2, width of all FSM state encodings
- CNT_WIDTH, 16, width of the iteration counters
- MAX_INFLIGHT, 8, legal maximum of iterations simultaneously in flight
- STALL_LIMIT, 1024, consecutive blocked cycles that raise stall_alarm
- clock  in  1  single design clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears every register immediately
- cur_state  in  FSM_WIDTH  current loop-FSM state
- pre_states_valid  in  1  pre_loop_state0 is meaningful
- pre_loop_state0  in  FSM_WIDTH  state preceding loop entry
- post_states_valid  in  2  bit i qualifies post_loop_state{i}
- post_loop_state0, post_loop_state1  in  FSM_WIDTH each  legal states after loop exit
- loop_quit_state  in  FSM_WIDTH  state where the exit condition is evaluated
- iter_start_state, iter_end_state  in  FSM_WIDTH each  first/last stage states of an iteration
- iter_start_enable, iter_start_block  in  1 each  start qualifiers
- iter_end_enable, iter_end_block  in  1 each  end qualifiers
- quit_at_end  in  1  loop quits only after the end stage of the last iteration
- loop_active  out  1  FSM in RUN or DRAIN
- iter_started, iter_ended  out  CNT_WIDTH each  iterations started/ended in current loop
- in_flight  out  $clog2(MAX_INFLIGHT+1)  started minus ended
- finish  out  1  one-cycle pulse on completed loop exit
- stall_alarm, overflow_err, underflow_err, exit_err  out  1 each  sticky flags

## Operation
- Events, combinational from sampled inputs: start_ev = (cur_state==iter_start_state) & iter_start_enable & ~iter_start_block. end_ev = (cur_state==iter_end_state) & iter_end_enable & ~iter_end_block. quit_ev = cur_state==loop_quit_state. post_hit = OR over i of post_states_valid[i] & (cur_state==post_loop_state{i}).
- FSM states: IDLE, ARMED, RUN, DRAIN.
- IDLE: pre_states_valid & cur_state==pre_loop_state0 -> ARMED. Else start_ev -> RUN, with that start counted.
- ARMED: start_ev -> RUN, with that start counted.
- Loop entry (into RUN) clears counters, in_flight and stall_alarm. It does not clear the error flags.
- RUN: start_ev increments iter_started and in_flight. end_ev increments iter_ended and decrements in_flight. Both in the same cycle leave in_flight unchanged.
- RUN: on quit_ev go to DRAIN. If quit_at_end=1 and in_flight (after this cycle's update) is nonzero, set exit_err.
- DRAIN: further start_ev sets exit_err and is not counted. end_ev is counted.
- DRAIN: when in_flight==0 and post_hit, pulse finish and go to IDLE.
- DRAIN: post_hit with in_flight!=0 sets exit_err, pulses finish and goes to IDLE.
- Overflow: a start that would make in_flight exceed MAX_INFLIGHT sets overflow_err. in_flight saturates at MAX_INFLIGHT.
- Underflow: end_ev with in_flight==0 and no simultaneous start sets underflow_err. in_flight stays 0 and iter_ended still increments.
- Counters wrap modulo 2^CNT_WIDTH; no flag on wrap.
- Stall counter: active in RUN/DRAIN. It increments on a cycle where (cur_state==iter_start_state & iter_start_block) or (cur_state==iter_end_state & iter_end_block). Any other cycle clears it. Reaching STALL_LIMIT sets stall_alarm, and the counter saturates.

## Timing
- All outputs registered. An event sampled at edge t is visible after edge t.
- finish is high exactly one cycle. Earliest finish is 1 cycle after the cycle in which the last end_ev and post_hit coincide.
- Reset value: FSM=IDLE; all outputs 0; stall counter 0.
- Reset asserted mid-loop aborts immediately, with no finish pulse. The first rising edge after deassertion samples normally.
- Loop re-entry is legal in the same cycle finish is produced: IDLE is evaluated on the next edge.
- Enable without block-release does not count. Block without enable does not stall-count unless the FSM state matches.

## Test plan
- Simple loop, 4-cycle stride, 5 iterations, pre state, quit_at_end=1, post_loop_state0 valid -> iter_started=5, iter_ended=5, in_flight max 1, one finish pulse, all flags 0.
- Pipelined II=1, depth 3, 10 iterations with start and end in the same cycles -> in_flight peaks at 3, final counts 10/10, finish one cycle after last end with post_hit.
- Start held blocked for STALL_LIMIT=16 cycles -> stall_alarm rises after the 16th blocked cycle and stays set. A new loop entry clears it.
- 9 starts with no ends, MAX_INFLIGHT=8 -> overflow_err=1, in_flight=8. A stray end in IDLE-entered loop with in_flight=0 -> underflow_err=1.
- Quit with in_flight=2 and quit_at_end=1 -> exit_err=1. DRAIN absorbs 2 ends, then finish on post_hit.
- Assert reset in DRAIN with in_flight=3 -> all outputs 0 within the same cycle, no finish, and the next loop counts from 0.

Source files
------------

// File: rtl/pp_loop_tracker.sv
// rtl/pp_loop_tracker.sv - pipelined-loop observation monitor: iteration counts, finish pulse, sticky error/stall flags
module pp_loop_tracker #(
    parameter int FSM_WIDTH    = 2,
    parameter int CNT_WIDTH    = 16,
    parameter int MAX_INFLIGHT = 8,
    parameter int STALL_LIMIT  = 1024
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [FSM_WIDTH-1:0]                   cur_state,
    input  logic                                   pre_states_valid,
    input  logic [FSM_WIDTH-1:0]                   pre_loop_state0,
    input  logic [1:0]                             post_states_valid,
    input  logic [FSM_WIDTH-1:0]                   post_loop_state0,
    input  logic [FSM_WIDTH-1:0]                   post_loop_state1,
    input  logic [FSM_WIDTH-1:0]                   loop_quit_state,
    input  logic [FSM_WIDTH-1:0]                   iter_start_state,
    input  logic [FSM_WIDTH-1:0]                   iter_end_state,
    input  logic                                   iter_start_enable,
    input  logic                                   iter_start_block,
    input  logic                                   iter_end_enable,
    input  logic                                   iter_end_block,
    input  logic                                   quit_at_end,
    output logic                                   loop_active,
    output logic [CNT_WIDTH-1:0]                   iter_started,
    output logic [CNT_WIDTH-1:0]                   iter_ended,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]      in_flight,
    output logic                                   finish,
    output logic                                   stall_alarm,
    output logic                                   overflow_err,
    output logic                                   underflow_err,
    output logic                                   exit_err
);

    localparam int IF_W = $clog2(MAX_INFLIGHT + 1);
    localparam int SC_W = $clog2(STALL_LIMIT + 1);

    localparam logic [IF_W-1:0]      IF_MAX  = IF_W'(MAX_INFLIGHT);
    localparam logic [IF_W-1:0]      IF_ONE  = IF_W'(1);
    localparam logic [SC_W-1:0]      SC_MAX  = SC_W'(STALL_LIMIT);
    localparam logic [SC_W-1:0]      SC_ONE  = SC_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t          state;
    logic [SC_W-1:0] stall_cnt;

    logic            start_ev;
    logic            end_ev;
    logic            quit_ev;
    logic            post_hit;
    logic            pre_hit;
    logic            stall_cond;
    logic            enter;
    logic            cnt_start;
    logic [IF_W-1:0] inf_nxt;
    logic            ovf_hit;
    logic            unf_hit;
    logic [SC_W-1:0] stall_nxt;

    assign start_ev   = (cur_state == iter_start_state) & iter_start_enable & ~iter_start_block;
    assign end_ev     = (cur_state == iter_end_state) & iter_end_enable & ~iter_end_block;
    assign quit_ev    = (cur_state == loop_quit_state);
    assign post_hit   = (post_states_valid[0] & (cur_state == post_loop_state0)) |
                        (post_states_valid[1] & (cur_state == post_loop_state1));
    assign pre_hit    = pre_states_valid & (cur_state == pre_loop_state0);
    assign stall_cond = ((cur_state == iter_start_state) & iter_start_block) |
                        ((cur_state == iter_end_state) & iter_end_block);

    // The pre-loop state wins over a coincident start while idle.
    assign enter     = ((state == S_IDLE) & ~pre_hit & start_ev) | ((state == S_ARMED) & start_ev);
    // Starts seen while draining are protocol errors and are not counted.
    assign cnt_start = start_ev & (state == S_RUN);

    always_comb begin
        inf_nxt = in_flight;
        ovf_hit = 1'b0;
        unf_hit = 1'b0;
        if (cnt_start && end_ev) begin
            inf_nxt = in_flight;
        end else if (cnt_start) begin
            if (in_flight == IF_MAX) begin
                ovf_hit = 1'b1;
            end else begin
                inf_nxt = in_flight + IF_ONE;
            end
        end else if (end_ev) begin
            if (in_flight == '0) begin
                unf_hit = 1'b1;
            end else begin
                inf_nxt = in_flight - IF_ONE;
            end
        end
    end

    always_comb begin
        stall_nxt = '0;
        if (stall_cond) begin
            stall_nxt = (stall_cnt == SC_MAX) ? SC_MAX : stall_cnt + SC_ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            loop_active   <= 1'b0;
            iter_started  <= '0;
            iter_ended    <= '0;
            in_flight     <= '0;
            finish        <= 1'b0;
            stall_alarm   <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            exit_err      <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            finish <= 1'b0;
            unique case (state)
                S_IDLE, S_ARMED: begin
                    if (enter) begin
                        state        <= S_RUN;
                        loop_active  <= 1'b1;
                        iter_started <= CNT_ONE;
                        iter_ended   <= '0;
                        in_flight    <= IF_ONE;
                        stall_alarm  <= 1'b0;
                        stall_cnt    <= '0;
                    end else if (state == S_IDLE && pre_hit) begin
                        state <= S_ARMED;
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (cnt_start) begin
                        iter_started <= iter_started + CNT_ONE;
                    end
                    if (end_ev) begin
                        iter_ended <= iter_ended + CNT_ONE;
                    end
                    in_flight <= inf_nxt;
                    if (ovf_hit) begin
                        overflow_err <= 1'b1;
                    end
                    if (unf_hit) begin
                        underflow_err <= 1'b1;
                    end
                    stall_cnt <= stall_nxt;
                    if (stall_nxt == SC_MAX) begin
                        stall_alarm <= 1'b1;
                    end
                    if (state == S_RUN) begin
                        if (quit_ev) begin
                            state <= S_DRAIN;
                            if (quit_at_end && inf_nxt != '0) begin
                                exit_err <= 1'b1;
                            end
                        end
                    end else begin
                        if (start_ev) begin
                            exit_err <= 1'b1;
                        end
                        // Exit on post state even with iterations outstanding, but flag it.
                        if (post_hit) begin
                            state       <= S_IDLE;
                            loop_active <= 1'b0;
                            finish      <= 1'b1;
                            if (inf_nxt != '0) begin
                                exit_err <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pp_loop_tracker.sv
// tb/tb_pp_loop_tracker.sv - scoreboard bench for pp_loop_tracker with directed loop scenarios
module tb_pp_loop_tracker;

    localparam int FW = 3;
    localparam int CW = 16;
    localparam int MI = 8;
    localparam int SL = 16;
    localparam int IW = $clog2(MI + 1);

    localparam logic [FW-1:0] S_IDL  = 3'd0;
    localparam logic [FW-1:0] S_PRE  = 3'd1;
    localparam logic [FW-1:0] S_ST   = 3'd2;
    localparam logic [FW-1:0] S_EN   = 3'd3;
    localparam logic [FW-1:0] S_Q    = 3'd4;
    localparam logic [FW-1:0] S_POST = 3'd5;
    localparam logic [FW-1:0] S_MID  = 3'd6;
    localparam logic [FW-1:0] S_PIPE = 3'd7;

    logic          clock = 1'b1;
    logic          reset;
    logic [FW-1:0] cur_state;
    logic          pre_states_valid;
    logic [FW-1:0] pre_loop_state0;
    logic [1:0]    post_states_valid;
    logic [FW-1:0] post_loop_state0;
    logic [FW-1:0] post_loop_state1;
    logic [FW-1:0] loop_quit_state;
    logic [FW-1:0] iter_start_state;
    logic [FW-1:0] iter_end_state;
    logic          iter_start_enable;
    logic          iter_start_block;
    logic          iter_end_enable;
    logic          iter_end_block;
    logic          quit_at_end;
    logic          loop_active;
    logic [CW-1:0] iter_started;
    logic [CW-1:0] iter_ended;
    logic [IW-1:0] in_flight;
    logic          finish;
    logic          stall_alarm;
    logic          overflow_err;
    logic          underflow_err;
    logic          exit_err;

    pp_loop_tracker #(
        .FSM_WIDTH(FW), .CNT_WIDTH(CW), .MAX_INFLIGHT(MI), .STALL_LIMIT(SL)
    ) dut (
        .clock(clock), .reset(reset), .cur_state(cur_state),
        .pre_states_valid(pre_states_valid), .pre_loop_state0(pre_loop_state0),
        .post_states_valid(post_states_valid), .post_loop_state0(post_loop_state0),
        .post_loop_state1(post_loop_state1), .loop_quit_state(loop_quit_state),
        .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
        .iter_start_enable(iter_start_enable), .iter_start_block(iter_start_block),
        .iter_end_enable(iter_end_enable), .iter_end_block(iter_end_block),
        .quit_at_end(quit_at_end), .loop_active(loop_active),
        .iter_started(iter_started), .iter_ended(iter_ended), .in_flight(in_flight),
        .finish(finish), .stall_alarm(stall_alarm), .overflow_err(overflow_err),
        .underflow_err(underflow_err), .exit_err(exit_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [CW-1:0] st;
        logic [CW-1:0] en;
        logic [IW-1:0] inf;
        logic          act;
        logic          stall;
        logic          ovf;
        logic          unf;
        logic          ext;
    } exp_t;

    typedef struct {
        string nm;
        exp_t  v;
    } chk_t;

    chk_t fin_q[$];
    chk_t snap_q[$];
    logic snap_req = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   fin_seen = 0;
    exp_t act_v;
    chk_t c_v;

    function automatic exp_t mk(input int s, input int e, input int f, input bit a,
                                input bit sa, input bit o, input bit u, input bit x);
        exp_t r;
        r.st = CW'(s); r.en = CW'(e); r.inf = IW'(f);
        r.act = a; r.stall = sa; r.ovf = o; r.unf = u; r.ext = x;
        return r;
    endfunction

    task automatic cmp(input string nm, input exp_t a, input exp_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got st=%0d en=%0d inf=%0d act=%b stall/ovf/unf/exit=%b%b%b%b, expected st=%0d en=%0d inf=%0d act=%b stall/ovf/unf/exit=%b%b%b%b",
                     nm, a.st, a.en, a.inf, a.act, a.stall, a.ovf, a.unf, a.ext,
                     e.st, e.en, e.inf, e.act, e.stall, e.ovf, e.unf, e.ext);
        end
    endtask

    // Monitor: compares on every finish pulse and on every snapshot request.
    always @(negedge clock) begin
        act_v = {iter_started, iter_ended, in_flight, loop_active,
                 stall_alarm, overflow_err, underflow_err, exit_err};
        if (snap_req) begin
            if (snap_q.size() == 0) begin
                total++; bad++;
                $display("FAIL snap_underrun: got request with empty queue, expected queued entry");
            end else begin
                c_v = snap_q.pop_front();
                cmp(c_v.nm, act_v, c_v.v);
            end
        end
        if (finish) begin
            fin_seen++;
            if (fin_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_finish: got finish=1 expected finish=0");
            end else begin
                c_v = fin_q.pop_front();
                cmp(c_v.nm, act_v, c_v.v);
            end
        end
    end

    task automatic step(input logic [FW-1:0] s);
        cur_state = s;
        @(posedge clock);
        #1;
        snap_req = 1'b0;
    endtask

    task automatic snap(input string nm, input exp_t e);
        chk_t c;
        c.nm = nm; c.v = e;
        snap_q.push_back(c);
        snap_req = 1'b1;
    endtask

    task automatic expect_finish(input string nm, input exp_t e);
        chk_t c;
        c.nm = nm; c.v = e;
        fin_q.push_back(c);
    endtask

    initial begin
        reset = 1'b1;
        cur_state = S_IDL;
        pre_states_valid = 1'b1;
        pre_loop_state0 = S_PRE;
        post_states_valid = 2'b01;
        post_loop_state0 = S_POST;
        post_loop_state1 = S_MID;
        loop_quit_state = S_Q;
        iter_start_state = S_ST;
        iter_end_state = S_EN;
        iter_start_enable = 1'b1;
        iter_start_block = 1'b0;
        iter_end_enable = 1'b1;
        iter_end_block = 1'b0;
        quit_at_end = 1'b1;
        #1;
        snap("reset_state", mk(0, 0, 0, 0, 0, 0, 0, 0));
        step(S_IDL);
        reset = 1'b0;
        step(S_IDL);

        // Simple loop: pre state, 4-cycle stride, 5 iterations
        step(S_PRE);
        snap("t1_armed", mk(0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            step(S_ST);
            if (i == 0) snap("t1_first_start", mk(1, 0, 1, 1, 0, 0, 0, 0));
            step(S_MID);
            step(S_MID);
            step(S_EN);
        end
        step(S_Q);
        expect_finish("t1_finish", mk(5, 5, 0, 0, 0, 0, 0, 0));
        step(S_POST);
        step(S_IDL);

        // Pipelined II=1, depth 3, start and end share one state
        iter_start_state = S_PIPE;
        iter_end_state = S_PIPE;
        post_loop_state0 = S_PIPE;
        post_states_valid = 2'b00;
        quit_at_end = 1'b0;
        for (int i = 0; i < 10; i++) begin
            iter_start_enable = 1'b1;
            iter_end_enable = (i >= 3);
            step(S_PIPE);
            if (i == 2) snap("t2_peak", mk(3, 0, 3, 1, 0, 0, 0, 0));
            if (i == 9) snap("t2_last_start", mk(10, 7, 3, 1, 0, 0, 0, 0));
        end
        iter_start_enable = 1'b0;
        iter_end_enable = 1'b0;
        step(S_Q);
        snap("t2_drain", mk(10, 7, 3, 1, 0, 0, 0, 0));
        iter_end_enable = 1'b1;
        step(S_PIPE);
        step(S_PIPE);
        post_states_valid = 2'b01;
        expect_finish("t2_finish", mk(10, 10, 0, 0, 0, 0, 0, 0));
        step(S_PIPE);
        post_states_valid = 2'b01;
        post_loop_state0 = S_POST;
        iter_start_state = S_ST;
        iter_end_state = S_EN;
        iter_start_enable = 1'b1;
        quit_at_end = 1'b1;
        step(S_IDL);

        // Stall: start held blocked for STALL_LIMIT cycles
        step(S_ST);
        iter_start_block = 1'b1;
        for (int i = 0; i < SL; i++) begin
            step(S_ST);
            if (i == SL - 2) snap("t3_before_limit", mk(1, 0, 1, 1, 0, 0, 0, 0));
            if (i == SL - 1) snap("t3_at_limit", mk(1, 0, 1, 1, 1, 0, 0, 0));
        end
        iter_start_block = 1'b0;
        step(S_MID);
        snap("t3_sticky", mk(1, 0, 1, 1, 1, 0, 0, 0));
        step(S_EN);
        step(S_Q);
        expect_finish("t3_finish", mk(1, 1, 0, 0, 1, 0, 0, 0));
        step(S_POST);
        step(S_IDL);
        step(S_ST);
        snap("t3_reentry_clears", mk(1, 0, 1, 1, 0, 0, 0, 0));
        step(S_EN);
        step(S_Q);
        expect_finish("t3_finish2", mk(1, 1, 0, 0, 0, 0, 0, 0));
        step(S_POST);
        step(S_IDL);

        // Overflow with 9 starts, then underflow with a stray end
        for (int i = 0; i < 9; i++) begin
            step(S_ST);
            if (i == 7) snap("t4_full", mk(8, 0, 8, 1, 0, 0, 0, 0));
            if (i == 8) snap("t4_overflow", mk(9, 0, 8, 1, 0, 1, 0, 0));
        end
        for (int i = 0; i < 9; i++) begin
            step(S_EN);
            if (i == 7) snap("t4_empty", mk(9, 8, 0, 1, 0, 1, 0, 0));
            if (i == 8) snap("t4_underflow", mk(9, 9, 0, 1, 0, 1, 1, 0));
        end
        step(S_Q);
        expect_finish("t4_finish", mk(9, 9, 0, 0, 0, 1, 1, 0));
        step(S_POST);
        step(S_IDL);

        // Quit with two in flight, drain them, exit via post state 1
        post_states_valid = 2'b10;
        post_loop_state1 = S_POST;
        step(S_ST);
        step(S_MID);
        step(S_ST);
        step(S_Q);
        snap("t5_exit_err", mk(2, 0, 2, 1, 0, 1, 1, 1));
        step(S_EN);
        step(S_EN);
        expect_finish("t5_finish", mk(2, 2, 0, 0, 0, 1, 1, 1));
        step(S_POST);
        post_states_valid = 2'b01;
        post_loop_state1 = S_MID;
        step(S_IDL);

        // Reset while draining with three in flight
        quit_at_end = 1'b0;
        step(S_ST);
        step(S_ST);
        step(S_ST);
        snap("t6_three", mk(3, 0, 3, 1, 0, 1, 1, 1));
        step(S_Q);
        reset = 1'b1;
        #1;
        snap("t6_reset_clear", mk(0, 0, 0, 0, 0, 0, 0, 0));
        step(S_POST);
        reset = 1'b0;
        step(S_ST);
        snap("t6_fresh_loop", mk(1, 0, 1, 1, 0, 0, 0, 0));
        step(S_EN);
        step(S_Q);
        expect_finish("t6_finish", mk(1, 1, 0, 0, 0, 0, 0, 0));
        step(S_POST);
        step(S_IDL);
        step(S_IDL);
        step(S_IDL);

        total++;
        if (fin_q.size() != 0) begin
            bad++;
            $display("FAIL missing_finish: got %0d pending finishes, expected 0", fin_q.size());
        end
        total++;
        if (snap_q.size() != 0) begin
            bad++;
            $display("FAIL pending_snap: got %0d pending snapshots, expected 0", snap_q.size());
        end
        total++;
        if (fin_seen != 7) begin
            bad++;
            $display("FAIL finish_count: got %0d, expected 7", fin_seen);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
